// File: rtl/sprite_animator.sv
// Sprite engine: places a scaled/mirrored multi-frame sprite, drives the sprite ROM
// address and emits a palette index with an opacity flag two clocks after DrawX/DrawY.
module sprite_animator #(
  parameter int SPR_W           = 64,
  parameter int SPR_H           = 64,
  parameter int FRAMES          = 4,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FRAME_HOLD      = 6,
  parameter int ADDR_W          = $clog2(SPR_W*SPR_H*FRAMES),
  localparam int FW             = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale_sh,
  input  logic              flip,
  input  logic              play,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_valid,
  output logic [FW-1:0]     cur_frame,
  output logic              anim_done
);
  localparam int LXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int LYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int HW  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t          state, state_n;
  logic [FW-1:0]   frame_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic            done_n;

  logic [9:0]      sh_px, sh_py;
  logic [1:0]      sh_sh;
  logic            sh_flip;

  // Geometry only changes at frame_start so a frame never tears.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      sh_px   <= '0;
      sh_py   <= '0;
      sh_sh   <= '0;
      sh_flip <= 1'b0;
    end else if (frame_start) begin
      sh_px   <= pos_x;
      sh_py   <= pos_y;
      sh_sh   <= (scale_sh == 2'd3) ? 2'd2 : scale_sh;
      sh_flip <= flip;
    end
  end

  // Stage 0: 12-bit box test so boxes near the screen edge clip instead of wrapping.
  logic [11:0]      x12, y12, px12, py12, bw, bh, ox, oy;
  logic             in_box;
  logic [LXW-1:0]   lx_raw, lx;
  logic [LYW-1:0]   ly;
  logic [ADDR_W-1:0] addr_n;

  assign x12    = {2'b00, DrawX};
  assign y12    = {2'b00, DrawY};
  assign px12   = {2'b00, sh_px};
  assign py12   = {2'b00, sh_py};
  assign bw     = 12'(SPR_W) << sh_sh;
  assign bh     = 12'(SPR_H) << sh_sh;
  assign in_box = (x12 >= px12) && (x12 < px12 + bw) && (y12 >= py12) && (y12 < py12 + bh);
  assign ox     = x12 - px12;
  assign oy     = y12 - py12;
  assign lx_raw = LXW'(ox >> sh_sh);
  assign lx     = sh_flip ? (LXW'(SPR_W - 1) - lx_raw) : lx_raw;
  assign ly     = LYW'(oy >> sh_sh);
  assign addr_n = ADDR_W'(int'(cur_frame) * SPR_W * SPR_H + int'(ly) * SPR_W + int'(lx));

  logic vld_d;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rom_address <= '0;
      vld_d       <= 1'b0;
      pix_idx     <= '0;
      pix_valid   <= 1'b0;
    end else begin
      if (in_box) rom_address <= addr_n;
      vld_d     <= in_box & blank;
      pix_idx   <= rom_q;
      pix_valid <= vld_d && (rom_q != IDX_W'(TRANSPARENT_IDX));
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur_frame <= '0;
      hold_cnt  <= '0;
      anim_done <= 1'b0;
    end else begin
      state     <= state_n;
      cur_frame <= frame_n;
      hold_cnt  <= hold_n;
      anim_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    frame_n = cur_frame;
    hold_n  = hold_cnt;
    done_n  = 1'b0;
    if (frame_start) begin
      unique case (state)
        S_IDLE: begin
          frame_n = '0;
          hold_n  = '0;
          if (play) state_n = S_PLAY;
        end
        S_PLAY: begin
          if (!play) begin
            state_n = S_IDLE;
            frame_n = '0;
            hold_n  = '0;
          end else if (hold_cnt != HW'(FRAME_HOLD - 1)) begin
            hold_n = hold_cnt + 1'b1;
          end else begin
            hold_n = '0;
            if (cur_frame != FW'(FRAMES - 1)) begin
              frame_n = cur_frame + 1'b1;
            end else if (loop) begin
              frame_n = '0;
            end else begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end
          end
        end
        S_DONE: begin
          // Restart needs play to drop for a frame first.
          if (!play) begin
            state_n = S_IDLE;
            frame_n = '0;
            hold_n  = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
endmodule
